bp_be_pipe_imul_param: RTL and testbench

BP_BE_PIPE_IMUL_PARAM -- requirements
Module: bp_be_pipe_imul_param

---
 rtl/bp_be_pkg.sv | 12 +
 rtl/bp_be_imul_stage.sv | 53 +++++
 rtl/bp_be_pipe_imul_param.sv | 92 +++++++++
 tb/tb_bp_be_pipe_imul_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared back-end types for the integer multiply pipe.
package bp_be_pkg;

    typedef enum logic [2:0] {
        e_mul    = 3'd0,
        e_mulh   = 3'd1,
        e_mulhsu = 3'd2,
        e_mulhu  = 3'd3,
        e_mulw   = 3'd4
    } bp_be_imul_op_e;

endpackage

// File: rtl/bp_be_imul_stage.sv
// bp_be_imul_stage: one pipeline register slice; valid and tag are reset, payload is not.
module bp_be_imul_stage
    import bp_be_pkg::*;
#(
    parameter int data_width_p = 128,
    parameter int tag_width_p  = 5
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    kill_i,
    input  logic                    v_i,
    input  logic [tag_width_p-1:0]  tag_i,
    input  bp_be_imul_op_e          op_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    v_o,
    output logic [tag_width_p-1:0]  tag_o,
    output bp_be_imul_op_e          op_o,
    output logic [data_width_p-1:0] data_o
);

    logic                    v_d, v_q;
    logic [tag_width_p-1:0]  tag_d, tag_q;
    bp_be_imul_op_e          op_d, op_q;
    logic [data_width_p-1:0] data_d, data_q;

    always_comb begin
        v_d    = v_i & ~kill_i;
        tag_d  = tag_i;
        op_d   = op_i;
        data_d = data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q   <= 1'b0;
            tag_q <= '0;
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        op_q   <= op_d;
        data_q <= data_d;
    end

    assign v_o    = v_q;
    assign tag_o  = tag_q;
    assign op_o   = op_q;
    assign data_o = data_q;

endmodule

// File: rtl/bp_be_pipe_imul_param.sv
// bp_be_pipe_imul_param: fixed-latency integer multiply pipe with partial flush.
// The full product is formed at issue and carried down a register chain; result select happens at retire.
module bp_be_pipe_imul_param
    import bp_be_pkg::*;
#(
    parameter int width_p      = 64,
    parameter int latency_p    = 4,
    parameter int kill_depth_p = 2,
    parameter int tag_width_p  = 5
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  bp_be_imul_op_e                   op_i,
    input  logic [width_p-1:0]               rs1_i,
    input  logic [width_p-1:0]               rs2_i,
    input  logic [tag_width_p-1:0]           tag_i,
    input  logic                             flush_i,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    output logic [tag_width_p-1:0]           tag_o,
    output logic [$clog2(latency_p+1)-1:0]   inflight_o
);

    localparam int half_lp       = width_p / 2;
    localparam int inflight_w_lp = $clog2(latency_p + 1);

    logic [width_p-1:0]     rs1_w, rs2_w;
    logic                   a_sgn, b_sgn;
    logic [width_p:0]       a_ext, b_ext;
    logic [2*width_p-1:0]   prod;
    logic [width_p-1:0]     res;
    logic [inflight_w_lp-1:0] inflight;

    logic                   v_s    [latency_p+1];
    logic [tag_width_p-1:0] tag_s  [latency_p+1];
    bp_be_imul_op_e         op_s   [latency_p+1];
    logic [2*width_p-1:0]   data_s [latency_p+1];

    // Low 2*width_p bits of the (width_p+1)-bit product are exact in two's complement.
    always_comb begin
        rs1_w = (op_i == e_mulw) ? {{half_lp{rs1_i[half_lp-1]}}, rs1_i[half_lp-1:0]} : rs1_i;
        rs2_w = (op_i == e_mulw) ? {{half_lp{rs2_i[half_lp-1]}}, rs2_i[half_lp-1:0]} : rs2_i;
        a_sgn = (op_i != e_mulhu);
        b_sgn = (op_i == e_mul) || (op_i == e_mulh) || (op_i == e_mulw);
        a_ext = {a_sgn & rs1_w[width_p-1], rs1_w};
        b_ext = {b_sgn & rs2_w[width_p-1], rs2_w};
        prod  = {{(width_p-1){a_ext[width_p]}}, a_ext} * {{(width_p-1){b_ext[width_p]}}, b_ext};
    end

    assign v_s[0]    = v_i;
    assign tag_s[0]  = tag_i;
    assign op_s[0]   = op_i;
    assign data_s[0] = prod;

    // Stage k's input holds the op leaving stage k-1, so kill it for k <= kill_depth_p.
    for (genvar k = 1; k <= latency_p; k++) begin : g_stage
        bp_be_imul_stage #(
            .data_width_p(2 * width_p),
            .tag_width_p (tag_width_p)
        ) stage (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .kill_i   (flush_i && (k <= kill_depth_p)),
            .v_i      (v_s[k-1]),
            .tag_i    (tag_s[k-1]),
            .op_i     (op_s[k-1]),
            .data_i   (data_s[k-1]),
            .v_o      (v_s[k]),
            .tag_o    (tag_s[k]),
            .op_o     (op_s[k]),
            .data_o   (data_s[k])
        );
    end

    always_comb begin
        inflight = '0;
        for (int k = 1; k <= latency_p; k++) inflight = inflight + inflight_w_lp'(v_s[k]);
    end

    always_comb begin
        res = (op_s[latency_p] == e_mul)  ? data_s[latency_p][width_p-1:0] :
              (op_s[latency_p] == e_mulw) ? {{half_lp{data_s[latency_p][half_lp-1]}}, data_s[latency_p][half_lp-1:0]} :
                                            data_s[latency_p][2*width_p-1:width_p];
    end

    assign v_o        = v_s[latency_p];
    assign tag_o      = tag_s[latency_p];
    assign data_o     = v_s[latency_p] ? res : '0;
    assign inflight_o = inflight;

endmodule

// File: tb/tb_bp_be_pipe_imul_param.sv
// tb_bp_be_pipe_imul_param: directed self-checking bench, width 64, latency 4, kill depth 2.
module tb_bp_be_pipe_imul_param;
    import bp_be_pkg::*;

    logic           clk_i     = 1'b0;
    logic           reset_n_i = 1'b1;
    logic           v_i       = 1'b0;
    logic           flush_i   = 1'b0;
    bp_be_imul_op_e op_i      = e_mul;
    logic [63:0]    rs1_i     = '0;
    logic [63:0]    rs2_i     = '0;
    logic [4:0]     tag_i     = '0;
    logic           v_o;
    logic [63:0]    data_o;
    logic [4:0]     tag_o;
    logic [2:0]     inflight_o;

    int checks = 0;
    int errors = 0;

    localparam int nv = 11;
    bp_be_imul_op_e vop [nv] = '{e_mulh, e_mulhu, e_mulhsu, e_mulw, e_mulhsu, e_mulh,
                                 e_mulhu, e_mulw, e_mul, e_mulw, e_mulh};
    logic [63:0] va [nv] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                             64'h000000007FFFFFFF, 64'h0000000000000002, 64'hFFFFFFFFFFFFFFFF,
                             64'hFFFFFFFFFFFFFFFF, 64'hDEADBEEF00000003, 64'hFFFFFFFFFFFFFFFF,
                             64'h0000000040000000, 64'h7FFFFFFFFFFFFFFF};
    logic [63:0] vb [nv] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002,
                             64'h0000000000000002, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002,
                             64'h0000000000000002, 64'h12345678FFFFFFFE, 64'hFFFFFFFFFFFFFFFF,
                             64'h0000000000000002, 64'h7FFFFFFFFFFFFFFF};
    logic [63:0] ve [nv] = '{64'h4000000000000000, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF,
                             64'hFFFFFFFFFFFFFFFE, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
                             64'h0000000000000001, 64'hFFFFFFFFFFFFFFFA, 64'h0000000000000001,
                             64'hFFFFFFFF80000000, 64'h3FFFFFFFFFFFFFFF};

    always #5 clk_i = ~clk_i;

    bp_be_pipe_imul_param #(
        .width_p     (64),
        .latency_p   (4),
        .kill_depth_p(2),
        .tag_width_p (5)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .op_i      (op_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .tag_i     (tag_i),
        .flush_i   (flush_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .tag_o     (tag_o),
        .inflight_o(inflight_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input bp_be_imul_op_e op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] t);
        v_i   = 1'b1;
        op_i  = op;
        rs1_i = a;
        rs2_i = b;
        tag_i = t;
    endtask

    task automatic idle;
        v_i = 1'b0;
    endtask

    initial begin
        int n;
        #1 reset_n_i = 1'b0;
        #1;
        chk("rst_v", 64'(v_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        chk("rst_inflight", 64'(inflight_o), 64'd0);
        tick;
        tick;
        reset_n_i = 1'b1;

        // single mul, latency and tag echo
        issue(e_mul, 64'd3, 64'hFFFFFFFFFFFFFFFE, 5'd5);
        chk("t1_inflight0", 64'(inflight_o), 64'd0);
        tick;
        idle;
        chk("t1_inflight1", 64'(inflight_o), 64'd1);
        chk("t1_v1", 64'(v_o), 64'd0);
        tick;
        tick;
        chk("t1_v3", 64'(v_o), 64'd0);
        tick;
        chk("t1_v4", 64'(v_o), 64'd1);
        chk("t1_data", data_o, 64'hFFFFFFFFFFFFFFFA);
        chk("t1_tag", 64'(tag_o), 64'd5);
        tick;
        chk("t1_v5", 64'(v_o), 64'd0);
        chk("t1_inflight5", 64'(inflight_o), 64'd0);

        // back-to-back op mix
        for (int c = 0; c < nv + 4; c++) begin
            if (c < nv) issue(vop[c], va[c], vb[c], 5'(c + 8));
            else idle;
            if (c >= 4) begin
                chk($sformatf("t2_v%0d", c - 4), 64'(v_o), 64'd1);
                chk($sformatf("t2_data%0d", c - 4), data_o, ve[c-4]);
                chk($sformatf("t2_tag%0d", c - 4), 64'(tag_o), 64'(c + 4));
            end else begin
                chk($sformatf("t2_idle%0d", c), 64'(v_o), 64'd0);
            end
            tick;
        end
        chk("t2_drain_v", 64'(v_o), 64'd0);
        chk("t2_drain_inflight", 64'(inflight_o), 64'd0);

        // flush kills presented op and stage 1
        for (int c = 0; c < 4; c++) begin
            issue(e_mul, 64'(c + 1), 64'd10, 5'(c));
            if (c == 3) begin
                flush_i = 1'b1;
                chk("t3_inflight_pre", 64'(inflight_o), 64'd3);
            end
            tick;
        end
        flush_i = 1'b0;
        idle;
        chk("t3_inflight_post", 64'(inflight_o), 64'd2);
        chk("t3_v4", 64'(v_o), 64'd1);
        chk("t3_tag4", 64'(tag_o), 64'd0);
        chk("t3_data4", data_o, 64'd10);
        tick;
        chk("t3_v5", 64'(v_o), 64'd1);
        chk("t3_tag5", 64'(tag_o), 64'd1);
        chk("t3_data5", data_o, 64'd20);
        chk("t3_inflight5", 64'(inflight_o), 64'd1);
        tick;
        chk("t3_v6", 64'(v_o), 64'd0);
        chk("t3_inflight6", 64'(inflight_o), 64'd0);
        tick;
        chk("t3_v7", 64'(v_o), 64'd0);

        // continuous issue for 20 cycles
        for (int c = 0; c < 25; c++) begin
            if (c < 20) issue(e_mul, 64'(c), 64'd3, 5'(c));
            else idle;
            n = 0;
            for (int i = c - 4; i < c; i++) if (i >= 0 && i < 20) n++;
            chk($sformatf("t4_inflight%0d", c), 64'(inflight_o), 64'(n));
            chk($sformatf("t4_v%0d", c), 64'(v_o), 64'(c >= 4 && c < 24));
            if (c >= 4 && c < 24) begin
                chk($sformatf("t4_tag%0d", c), 64'(tag_o), 64'(c - 4));
                chk($sformatf("t4_data%0d", c), data_o, 64'((c - 4) * 3));
            end
            tick;
        end

        // reset mid-stream with three ops in flight
        for (int c = 0; c < 3; c++) begin
            issue(e_mul, 64'(c + 1), 64'd7, 5'(c + 21));
            tick;
        end
        idle;
        chk("t5_inflight3", 64'(inflight_o), 64'd3);
        tick;
        chk("t5_v_pre", 64'(v_o), 64'd1);
        chk("t5_tag_pre", 64'(tag_o), 64'd21);
        #2 reset_n_i = 1'b0;
        #1;
        chk("t5_rst_v", 64'(v_o), 64'd0);
        chk("t5_rst_data", data_o, 64'd0);
        chk("t5_rst_tag", 64'(tag_o), 64'd0);
        chk("t5_rst_inflight", 64'(inflight_o), 64'd0);
        tick;
        tick;
        reset_n_i = 1'b1;
        issue(e_mulhu, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd9);
        tick;
        idle;
        for (int c = 1; c < 9; c++) begin
            chk($sformatf("t5_post_v%0d", c), 64'(v_o), 64'(c == 4));
            if (c == 4) begin
                chk("t5_post_tag", 64'(tag_o), 64'd9);
                chk("t5_post_data", data_o, 64'd1);
            end
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
